nmul_sched: RTL and testbench
=============================

# nmul_sched

Round-robin scheduler that shares one pipelined N-bit × N-bit multiplier (the `NMul` datapath) among `Nreq` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one requester per cycle and drives the multiplier operand port. It tracks each in-flight operation with a requester tag and returns every product with that tag. It sits between the requesting blocks and the single multiplier instance.

## Interface
- `Nsize`, 4, operand width in bits
- `Nreq`, 4, number of requesters (≥2)
- `Lat`, 2, multiplier latency in cycles from `MulA`/`MulB` valid to `MulR` valid (≥1)

- `Clk` input 1: single clock, rising edge
- `Clr` input 1: synchronous, active-high reset
- `ReqValid` input `Nreq`: per-requester request valid
- `ReqA` input `Nreq*Nsize`: operand A, requester i in bits [i*Nsize +: Nsize]
- `ReqB` input `Nreq*Nsize`: operand B, same packing
- `ReqReady` output `Nreq`: one-hot grant, combinational
- `MulA` output `Nsize`: registered operand A to multiplier
- `MulB` output `Nsize`: registered operand B to multiplier
- `MulR` input `2*Nsize`: multiplier product
- `RspValid` output 1: product valid, one-cycle pulse per accepted request
- `RspId` output clog2(`Nreq`): requester index of the product
- `RspR` output `2*Nsize`: product

## Operation
- Handshake: request i is accepted at a rising edge where `ReqValid[i] & ReqReady[i]`. Requesters hold `ReqA`/`ReqB` stable until accepted.
- Arbitration: `ReqReady` = first asserted `ReqValid` searching from (`Ptr`+1) mod `Nreq` upward with wrap-around. All zero if no valid.
- `Ptr` updates to the granted index on accept and holds otherwise.
- Issue: on accept, `MulA`/`MulB` load the granted operands. A tag shift pipeline of depth `Lat`+1 loads {1, id} at the accept edge and loads {0, x} on cycles with no accept.
- Response: when the tag pipeline stage `Lat` is valid, the next edge registers `RspR`←`MulR`, `RspId`←tag id, `RspValid`←1. Otherwise `RspValid`←0 and `RspR`/`RspId` hold.
- There is no response backpressure. Requesters must sink `RspValid` pulses every cycle.
- Width: the product is the full `2*Nsize` bits, unsigned, with no truncation. Max case: (2^Nsize−1)^2.
- Reset (`Clr`=1 at an edge):
  - `Ptr`←`Nreq`−1, so requester 0 has first priority.
  - Tag pipeline cleared, `RspValid`←0, `RspR`←0, `RspId`←0, `MulA`/`MulB`←0.
  - `ReqReady` is forced to 0 while `Clr`=1.
  - In-flight operations are discarded. No response is ever produced for them, even if `MulR` later shows a value.

## Timing
- Throughput: one accept per cycle, sustained.
- Latency: accept at edge k → `MulA`/`MulB` valid after edge k → `RspValid` high for the single cycle following edge k+`Lat`+1.
- Responses return in accept order, and each `RspValid` pulse is exactly one cycle wide.
- Simultaneous requests are resolved by `Ptr` only. There is no starvation: any continuously valid requester is granted within `Nreq` cycles.
- A requester dropping `ReqValid` while ungranted is legal and causes no side effects.

## Configuration
- `NMUL_SCHED_STATS_EN` defined:
  - Adds output `GrantCnt`, width `Nreq*16`.
  - Each 16-bit counter increments on that requester's accept and saturates at 16'hFFFF.
  - `Clr` zeroes all counters.
- Not defined: the `GrantCnt` port and its counters are absent. All other behaviour is identical.

## Structure
- `nmul_sched_pkg`:
  - Default constants `NSIZE_DEF`, `NREQ_DEF`, `LAT_DEF`, `CNT_W`=16.
  - Tag struct typedef {valid, id}.
  - Id-width function clog2(`Nreq`).
- Sub-module `rr_arbiter`:
  - Ports: `Clk`, `Clr`, `Req`[`Nreq`], `Accept`, `Gnt`[`Nreq`].
  - Contains `Ptr` and the one-hot priority search.
- The top level holds the operand registers, the tag pipeline, the response registers and the optional counters.

## Test plan
All scenarios use defaults `Nsize`=4, `Nreq`=4, `Lat`=2, with a behavioural `Lat`-cycle multiplier model on `MulA`/`MulB`→`MulR`.
- Single request: requester 2 with A=3, B=5, accepted at edge k → `RspValid`=1, `RspId`=2, `RspR`=15 in the cycle after edge k+3, and `RspValid`=0 in all other cycles.
- Full contention: all four `ReqValid` held high for 8 cycles after reset → grants 0,1,2,3,0,1,2,3. Responses arrive in the same id order, one per cycle, each product correct.
- Sparse wrap: after a grant to 3, only requesters 1 and 3 valid → grant 1, then 3, then 1.
- Boundary: A=15, B=15 → `RspR`=225. A=0, B=15 → `RspR`=0.
- Reset mid-flight: accept two requests, assert `Clr` one cycle later → no `RspValid` pulse at any time, and the next post-reset request from requester 1 completes normally with correct latency.
- With `NMUL_SCHED_STATS_EN` defined: 5 accepts of requester 0 → `GrantCnt[15:0]`=5, other counters 0. `Clr` then zeroes all counters.

Source files
------------

// File: rtl/nmul_sched_pkg.sv
// Shared constants, tag type and id-width helper for the nmul_sched multiplier scheduler.
package nmul_sched_pkg;

   localparam int NSIZE_DEF = 4;
   localparam int NREQ_DEF  = 4;
   localparam int LAT_DEF   = 2;
   localparam int CNT_W     = 16;
   // Tag id is stored at a fixed width; the top level keeps only the low id bits.
   localparam int TAG_ID_W  = 8;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   function automatic int id_width(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/nmul_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the slot after the last grant.
module rr_arbiter
   import nmul_sched_pkg::*;
#(
   parameter int Nreq = NREQ_DEF
) (
   input  logic            Clk,
   input  logic            Clr,
   input  logic [Nreq-1:0] Req,
   input  logic            Accept,
   output logic [Nreq-1:0] Gnt
);

   localparam int IdW = id_width(Nreq);

   logic [IdW-1:0]  ptr_r;
   logic [Nreq-1:0] gnt_s;
   logic [IdW-1:0]  gnt_id_s;

   // Priority search with wrap-around; grant is suppressed while Clr is high.
   always_comb begin
      logic           found_s;
      logic [IdW-1:0] idx_s;
      gnt_s    = {Nreq{1'b0}};
      gnt_id_s = {IdW{1'b0}};
      found_s  = 1'b0;
      idx_s    = {IdW{1'b0}};
      for (int off = 1; off <= Nreq; off++) begin
         idx_s = IdW'((int'(ptr_r) + off) % Nreq);
         if (!found_s && Req[idx_s]) begin
            gnt_s[idx_s] = 1'b1;
            gnt_id_s     = idx_s;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      if (Clr) begin
         gnt_s = {Nreq{1'b0}};
      end else begin
         gnt_s = gnt_s;
      end
   end

   assign Gnt = gnt_s;

   // Pointer remembers the last granted requester so it drops to lowest priority.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         ptr_r <= IdW'(Nreq - 1);
      end else if (Accept) begin
         ptr_r <= gnt_id_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/nmul_sched.sv
// Shares one pipelined multiplier among Nreq requesters and returns tagged products in order.
// Optional per-requester grant counters are built when NMUL_SCHED_STATS_EN is defined.
module nmul_sched
   import nmul_sched_pkg::*;
#(
   parameter int Nsize = NSIZE_DEF,
   parameter int Nreq  = NREQ_DEF,
   parameter int Lat   = LAT_DEF
) (
   input  logic                      Clk,
   input  logic                      Clr,
   input  logic [Nreq-1:0]           ReqValid,
   input  logic [Nreq*Nsize-1:0]     ReqA,
   input  logic [Nreq*Nsize-1:0]     ReqB,
   output logic [Nreq-1:0]           ReqReady,
   output logic [Nsize-1:0]          MulA,
   output logic [Nsize-1:0]          MulB,
   input  logic [2*Nsize-1:0]        MulR,
   output logic                      RspValid,
   output logic [id_width(Nreq)-1:0] RspId,
   output logic [2*Nsize-1:0]        RspR
`ifdef NMUL_SCHED_STATS_EN
   ,output logic [Nreq*CNT_W-1:0]    GrantCnt
`endif
);

   localparam int IdW = id_width(Nreq);

   logic [Nreq-1:0]  gnt_s;
   logic             accept_s;
   logic [IdW-1:0]   gnt_id_s;
   logic [Nsize-1:0] a_sel_s;
   logic [Nsize-1:0] b_sel_s;
   tag_t             tag_r [0:Lat];

   rr_arbiter #(.Nreq(Nreq)) u_arb (
      .Clk    (Clk),
      .Clr    (Clr),
      .Req    (ReqValid),
      .Accept (accept_s),
      .Gnt    (gnt_s)
   );

   assign ReqReady = gnt_s;
   assign accept_s = |(ReqValid & gnt_s);

   // One-hot grant to index and operand mux; OR-reduction is exact because the grant is one-hot.
   always_comb begin
      gnt_id_s = {IdW{1'b0}};
      a_sel_s  = {Nsize{1'b0}};
      b_sel_s  = {Nsize{1'b0}};
      for (int i = 0; i < Nreq; i++) begin
         gnt_id_s = gnt_id_s | (gnt_s[i] ? IdW'(i) : {IdW{1'b0}});
         a_sel_s  = a_sel_s | (gnt_s[i] ? ReqA[i*Nsize +: Nsize] : {Nsize{1'b0}});
         b_sel_s  = b_sel_s | (gnt_s[i] ? ReqB[i*Nsize +: Nsize] : {Nsize{1'b0}});
      end
   end

   // Operand registers feeding the multiplier.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         MulA <= {Nsize{1'b0}};
         MulB <= {Nsize{1'b0}};
      end else if (accept_s) begin
         MulA <= a_sel_s;
         MulB <= b_sel_s;
      end else begin
         MulA <= MulA;
         MulB <= MulB;
      end
   end

   // Tag pipeline tracks each issued operation until its product reaches MulR.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         for (int j = 0; j <= Lat; j++) begin
            tag_r[j] <= '0;
         end
      end else begin
         tag_r[0] <= accept_s ? tag_t'{valid: 1'b1, id: TAG_ID_W'(gnt_id_s)}
                              : tag_t'{valid: 1'b0, id: {TAG_ID_W{1'b0}}};
         for (int j = 1; j <= Lat; j++) begin
            tag_r[j] <= tag_r[j-1];
         end
      end
   end

   // Response capture; product and id hold between pulses.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         RspValid <= 1'b0;
         RspR     <= {(2*Nsize){1'b0}};
         RspId    <= {IdW{1'b0}};
      end else if (tag_r[Lat].valid) begin
         RspValid <= 1'b1;
         RspR     <= MulR;
         RspId    <= tag_r[Lat].id[IdW-1:0];
      end else begin
         RspValid <= 1'b0;
         RspR     <= RspR;
         RspId    <= RspId;
      end
   end

`ifdef NMUL_SCHED_STATS_EN
   logic [CNT_W-1:0] cnt_r [Nreq];

   // Saturating per-requester accept counters.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < Nreq; i++) begin
         if (Clr) begin
            cnt_r[i] <= {CNT_W{1'b0}};
         end else if (ReqValid[i] && gnt_s[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
            cnt_r[i] <= cnt_r[i] + CNT_W'(1);
         end else begin
            cnt_r[i] <= cnt_r[i];
         end
      end
   end

   for (genvar g = 0; g < Nreq; g++) begin : g_cnt
      assign GrantCnt[g*CNT_W +: CNT_W] = cnt_r[g];
   end
`endif

endmodule

// File: tb/tb_nmul_sched.sv
// Directed plus random bench for nmul_sched with a queue-based reference model and a Lat-cycle multiplier.
module tb_nmul_sched;

   localparam int NS = 4;
   localparam int NR = 4;
   localparam int LT = 2;
   localparam int PW = 2 * NS;

   logic             Clk = 1'b0;
   logic             Clr;
   logic [NR-1:0]    ReqValid;
   logic [NR*NS-1:0] ReqA;
   logic [NR*NS-1:0] ReqB;
   logic [NR-1:0]    ReqReady;
   logic [NS-1:0]    MulA;
   logic [NS-1:0]    MulB;
   logic [PW-1:0]    MulR;
   logic             RspValid;
   logic [1:0]       RspId;
   logic [PW-1:0]    RspR;
`ifdef NMUL_SCHED_STATS_EN
   logic [NR*16-1:0] GrantCnt;
`endif

   always #5 Clk = ~Clk;

   nmul_sched #(.Nsize(NS), .Nreq(NR), .Lat(LT)) dut (
      .Clk      (Clk),
      .Clr      (Clr),
      .ReqValid (ReqValid),
      .ReqA     (ReqA),
      .ReqB     (ReqB),
      .ReqReady (ReqReady),
      .MulA     (MulA),
      .MulB     (MulB),
      .MulR     (MulR),
      .RspValid (RspValid),
      .RspId    (RspId),
      .RspR     (RspR)
`ifdef NMUL_SCHED_STATS_EN
      ,.GrantCnt (GrantCnt)
`endif
   );

   // Behavioural multiplier: product appears LT cycles after the operands.
   logic [PW-1:0] mpipe [LT];
   always_ff @(posedge Clk) begin
      mpipe[0] <= PW'(MulA) * PW'(MulB);
      for (int i = 1; i < LT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign MulR = mpipe[LT-1];

   typedef struct { int due; int id; int prod; } exp_t;

   int   total = 0;
   int   bad = 0;
   int   ecnt = 0;
   int   ptr_m = NR - 1;
   bit   clr_m;
   bit   rnd_ops;
   bit   vld [NR];
   int   opa [NR];
   int   opb [NR];
   int   cnt_m [NR];
   exp_t q [$];
   int   glog [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, ecnt);
      end
   endtask

   // One clock: drive inputs, check grant, update model at the edge, check registered outputs.
   task automatic cycle();
      int g;
      logic [NR-1:0] er;
      Clr = clr_m;
      for (int i = 0; i < NR; i++) begin
         ReqValid[i]        = vld[i];
         ReqA[i*NS +: NS]   = NS'(opa[i]);
         ReqB[i*NS +: NS]   = NS'(opb[i]);
      end
      @(negedge Clk);
      g = -1;
      if (!clr_m) begin
         for (int off = 1; off <= NR; off++) begin
            int j;
            j = (ptr_m + off) % NR;
            if (g < 0 && vld[j]) g = j;
         end
      end
      er = (g >= 0) ? (NR'(1) << g) : NR'(0);
      chk("ready", 32'(ReqReady), 32'(er));
      @(posedge Clk);
      ecnt++;
      if (clr_m) begin
         q.delete();
         ptr_m = NR - 1;
         for (int i = 0; i < NR; i++) cnt_m[i] = 0;
      end else if (g >= 0) begin
         q.push_back('{ecnt + LT + 1, g, opa[g] * opb[g]});
         ptr_m = g;
         glog.push_back(g);
         if (cnt_m[g] < 65535) cnt_m[g]++;
      end
      #1;
      if (clr_m) begin
         chk("rst_rspvalid", 32'(RspValid), 32'd0);
         chk("rst_rspr", 32'(RspR), 32'd0);
         chk("rst_rspid", 32'(RspId), 32'd0);
         chk("rst_mula", 32'(MulA), 32'd0);
         chk("rst_mulb", 32'(MulB), 32'd0);
      end else begin
         if (g >= 0) begin
            chk("mula", 32'(MulA), opa[g]);
            chk("mulb", 32'(MulB), opb[g]);
            if (rnd_ops) begin
               opa[g] = int'($urandom_range(0, 15));
               opb[g] = int'($urandom_range(0, 15));
            end
         end
         if (q.size() > 0 && q[0].due == ecnt) begin
            chk("rspvalid", 32'(RspValid), 32'd1);
            chk("rspid", 32'(RspId), q[0].id);
            chk("rspr", 32'(RspR), q[0].prod);
            void'(q.pop_front());
         end else begin
            chk("rspvalid_idle", 32'(RspValid), 32'd0);
         end
      end
   endtask

   task automatic all_idle();
      for (int i = 0; i < NR; i++) vld[i] = 1'b0;
   endtask

   initial begin
      clr_m   = 1'b1;
      rnd_ops = 1'b0;
      for (int i = 0; i < NR; i++) begin
         vld[i] = 1'b0; opa[i] = 0; opb[i] = 0; cnt_m[i] = 0;
      end
      repeat (2) cycle();
      clr_m = 1'b0;
      cycle();

      // Single request from requester 2: 3 * 5
      glog.delete();
      vld[2] = 1'b1; opa[2] = 3; opb[2] = 5;
      cycle();
      vld[2] = 1'b0;
      repeat (5) cycle();
      chk("single_gnt", glog.size() > 0 ? glog[0] : -1, 32'd2);

      // Full contention from reset
      clr_m = 1'b1; cycle(); clr_m = 1'b0;
      glog.delete();
      rnd_ops = 1'b1;
      for (int i = 0; i < NR; i++) begin
         vld[i] = 1'b1;
         opa[i] = int'($urandom_range(0, 15));
         opb[i] = int'($urandom_range(0, 15));
      end
      repeat (8) cycle();
      for (int i = 0; i < 8; i++) chk("contention_order", i < glog.size() ? glog[i] : -1, i % NR);

      // Sparse wrap: only 1 and 3 after a grant to 3
      glog.delete();
      all_idle();
      vld[1] = 1'b1; vld[3] = 1'b1;
      repeat (3) cycle();
      all_idle();
      chk("sparse0", glog.size() > 0 ? glog[0] : -1, 32'd1);
      chk("sparse1", glog.size() > 1 ? glog[1] : -1, 32'd3);
      chk("sparse2", glog.size() > 2 ? glog[2] : -1, 32'd1);
      repeat (5) cycle();

      // Boundary products
      rnd_ops = 1'b0;
      vld[0] = 1'b1; opa[0] = 15; opb[0] = 15;
      cycle();
      vld[0] = 1'b0; vld[1] = 1'b1; opa[1] = 0; opb[1] = 15;
      cycle();
      vld[1] = 1'b0;
      repeat (5) cycle();

      // Reset with two operations in flight
      rnd_ops = 1'b1;
      vld[0] = 1'b1; vld[1] = 1'b1;
      repeat (2) cycle();
      all_idle();
      clr_m = 1'b1; cycle(); clr_m = 1'b0;
      repeat (6) cycle();
      vld[1] = 1'b1;
      cycle();
      vld[1] = 1'b0;
      repeat (5) cycle();

      // Random traffic with valids that may drop while ungranted
      repeat (300) begin
         for (int i = 0; i < NR; i++) vld[i] = 1'($urandom_range(0, 1));
         cycle();
      end
      all_idle();
      repeat (6) cycle();
      chk("drain", q.size(), 32'd0);

`ifdef NMUL_SCHED_STATS_EN
      clr_m = 1'b1; cycle(); clr_m = 1'b0;
      vld[0] = 1'b1;
      repeat (5) cycle();
      vld[0] = 1'b0;
      cycle();
      chk("cnt0_five", 32'(GrantCnt[15:0]), 32'd5);
      for (int i = 0; i < NR; i++) chk("cnt_model", 32'(GrantCnt[i*16 +: 16]), cnt_m[i]);
      clr_m = 1'b1; cycle(); clr_m = 1'b0;
      for (int i = 0; i < NR; i++) chk("cnt_clr", 32'(GrantCnt[i*16 +: 16]), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
